// File: rtl/mw_store_buffer.sv
// Posted-write store buffer between the MW stage and the data memory port.
// In-order FIFO drain, youngest-entry coalescing and load forwarding.
module mw_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic                     st_v,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    output logic                     st_full,
    input  logic [AW-1:0]            ld_addr,
    input  logic                     ld_re,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_data,
    input  logic                     mem_wfin,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      head_q, head_d;
    logic [PW-1:0]      tail_q, tail_d;
    logic [PW-1:0]      young_idx;
    logic [PW-1:0]      fwd_idx;
    logic               full_q, full_d;
    logic               ovf_q, ovf_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [AW-1:0]      addr_q [DEPTH];
    logic [DW-1:0]      data_q [DEPTH];
    logic [CW-1:0]      count_d;
    logic               retire, coalesce, push, drop;

    // Pointers alone are ambiguous when head == tail, so the full flag disambiguates.
    assign count     = full_q ? CW'(DEPTH) : {1'b0, tail_q - head_q};
    assign st_full   = full_q;
    assign ovf       = ovf_q;
    assign young_idx = tail_q - PW'(1);
    assign mem_we    = (state_q == StWrite);
    assign mem_addr  = addr_q[head_q];
    assign mem_data  = data_q[head_q];

    always_comb begin
        retire   = (state_q == StWrite) && mem_wfin;
        // The head is frozen while it is being written, so it never absorbs a coalesce.
        coalesce = st_v && (count != '0) && (addr_q[young_idx] == st_addr)
                   && !((state_q == StWrite) && (young_idx == head_q));
        push     = st_v && !coalesce && !full_q;
        drop     = st_v && !coalesce && full_q;

        count_d  = count + CW'(push) - CW'(retire);
        full_d   = (count_d == CW'(DEPTH));
        head_d   = retire ? head_q + PW'(1) : head_q;
        tail_d   = push ? tail_q + PW'(1) : tail_q;
        ovf_d    = ovf_q | drop;
        state_d  = (count_d != '0) ? StWrite : StIdle;

        valid_d = valid_q;
        if (retire) valid_d[head_q] = 1'b0;
        if (push)   valid_d[tail_q] = 1'b1;
    end

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if (ld_re && valid_q[fwd_idx] && (addr_q[fwd_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end else if (coalesce) begin
            data_q[young_idx] <= st_data;
        end
    end

endmodule

// File: doc/mw_store_buffer.md
Name: mw_store_buffer

Overview:
- Posted-write buffer directly downstream of the memory-write (MW) stage, between the MW stage and the data memory port.
- Accepts stores (mwe, address, ALU value) from the MW stage in one cycle, queues them in order, and drains them to memory with the w_finished handshake.
- Forwards buffered data to the memory-read (MR) stage when a read address matches a pending store.
- Raises st_full so pipeline control can stall the pipe when no entry is free.

Parameters:
DEPTH, 4, number of buffer entries (power of two, >=2)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on posedge
r  in  1  synchronous reset, active-high
st_v  in  1  store request from MW stage (mwe)
st_addr  in  AW  store address (mw_addr)
st_data  in  DW  store data (mw_aluval)
st_full  out  1  buffer full; stores are not accepted
ld_addr  in  AW  MR-stage read address (mr_addr)
ld_re  in  1  MR-stage read enable (mre)
fwd_hit  out  1  ld_addr matches a valid entry while ld_re=1
fwd_data  out  DW  data of youngest matching entry
mem_we  out  1  write request to memory
mem_addr  out  AW  write address (head entry)
mem_data  out  DW  write data (head entry)
mem_wfin  in  1  memory write finished (w_finished)
count  out  log2(DEPTH)+1  number of valid entries
ovf  out  1  sticky: a store was dropped while full

Behaviour:
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH; per-entry valid, addr, data.
- Reset (r=1 at posedge): valid bits, pointers, count, ovf and state are cleared; next cycle mem_we=0, st_full=0, fwd_hit=0, count=0. Reset overrides everything, including an in-flight write; the entry is discarded.
- Drain FSM:
  - IDLE: mem_we=0. Moves to WRITE when count>0 at posedge.
  - WRITE: mem_we=1; mem_addr/mem_data are held from registered head entry and stay stable until retire.
  - Retire on posedge with mem_we=1 and mem_wfin=1: head valid cleared, head++.
  - After retire, go to WRITE if count after update >0, else IDLE. No idle cycle is inserted between back-to-back entries.
  - mem_wfin while mem_we=0 is ignored.
- Push: at posedge, st_v=1 and st_full=0 writes the tail entry and increments tail.
  - Latency: store pushed into an empty buffer at edge N gives mem_we=1 during cycle N+1. Earliest retire is edge N+1.
- Coalescing: if st_v hits the youngest valid entry's address, and that entry is not the head while in WRITE, its data is overwritten in place. No new entry is allocated and count is unchanged.
- Full: st_full = (count==DEPTH), registered-state based. It does not account for a same-cycle retire.
  - st_v=1 while st_full=1: store dropped, ovf set and held until reset.
  - Coalescing into a full buffer is still allowed and does not set ovf.
- Simultaneous push and retire: both occur; count unchanged. If count==1 and the head retires while a new push arrives, the FSM stays in WRITE with the new head.
- Forwarding: combinational.
  - fwd_hit = ld_re & any valid entry with addr==ld_addr.
  - fwd_data = data of youngest (closest to tail) matching entry; 0 when no hit.
  - Same-cycle incoming store is not forwarded; visible from the next cycle.
  - An entry retiring this cycle still forwards this cycle.
- Arithmetic: full-width address compare, no partial/byte matching; count = tail-head with wrap, plus full flag.

Test Plan:
- Reset then single store: st_v=1, addr=0x10, data=0xABCD at edge 1; mem_wfin=1 on cycle 2 -> mem_we=1, mem_addr=0x10, mem_data=0xABCD in cycle 2; count 1->0; mem_we=0 cycle 3.
- Fill and overflow: mem_wfin=0, push addrs 0x0,0x4,0x8,0xC -> st_full=1, count=4. Push 0x20 -> dropped, ovf=1. Then mem_wfin=1 for four cycles -> writes drain in order 0x0,0x4,0x8,0xC; count=0; ovf still 1.
- Forwarding priority: push (0x40,0x1111), (0x44,0x2222), (0x40,0x3333) with 0x44 between so no coalesce; ld_re=1, ld_addr=0x40 -> fwd_hit=1, fwd_data=0x3333. ld_addr=0x48 -> fwd_hit=0, fwd_data=0.
- Coalesce: mem_wfin=0, push (0x8,0x5) then (0xC,0x6) then (0xC,0x7) -> count=2; second write to memory carries data 0x7.
- Simultaneous push/retire at count==DEPTH-1=3 with mem_wfin=1 -> count stays 3, st_full stays 0, pointer wrap verified over 3 DEPTH cycles of traffic.
- Reset mid-write: 2 entries, mem_we=1, assert r one cycle -> next cycle mem_we=0, count=0, fwd_hit=0; a later mem_wfin pulse is ignored.
